// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
// Captures up to two retire/exception records per cycle from a dual-issue
// commit stage, stamps them with a free-running cycle counter and queues them
// in a circular FIFO for a trace consumer. Records that do not fit are dropped
// (port 1 first), counted in a saturating counter and flagged sticky.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   en_i                      capture enable
//   commit_*_i [1:0]          per-port retire payload, port 0 is older
//   rec_valid_o/rec_ready_i   output handshake
//   rec_*_o                   head record (cycle stamp + payload)
//   drop_cnt_o, overflow_o    lost-record count and sticky overflow flag
module commit_trace_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned VLEN  = 39,
  parameter int unsigned XLEN  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [1:0]            commit_valid_i,
  input  logic [1:0][VLEN-1:0]  commit_pc_i,
  input  logic [1:0][31:0]      commit_instr_i,
  input  logic [1:0][4:0]       commit_rd_i,
  input  logic [1:0]            commit_fpr_i,
  input  logic [1:0][XLEN-1:0]  commit_wdata_i,
  input  logic [1:0]            commit_exc_i,
  input  logic [1:0][5:0]       commit_cause_i,
  output logic                  rec_valid_o,
  input  logic                  rec_ready_i,
  output logic [31:0]           rec_cycle_o,
  output logic [VLEN-1:0]       rec_pc_o,
  output logic [31:0]           rec_instr_o,
  output logic [4:0]            rec_rd_o,
  output logic                  rec_fpr_o,
  output logic [XLEN-1:0]       rec_wdata_o,
  output logic                  rec_exc_o,
  output logic [5:0]            rec_cause_o,
  output logic [15:0]           drop_cnt_o,
  output logic                  overflow_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = 32 + VLEN + 32 + 5 + 1 + XLEN + 1 + 6;

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_occ;
  logic [31:0]   r_cycle;
  logic [15:0]   r_drop_cnt;
  logic          r_overflow;
  logic [RW-1:0] r_mem [DEPTH];

  logic [1:0]    w_req;
  logic [1:0]    w_nreq;
  logic [1:0]    w_nacc;
  logic [1:0]    w_ndrop;
  logic [CW-1:0] w_free;
  logic          w_pop;
  logic [AW-1:0] w_wptr1;
  logic [16:0]   w_drop_sum;
  logic [RW-1:0] w_rec [2];
  logic [RW-1:0] w_first_rec;

  // Capacity decision is based on start-of-cycle occupancy only
  always_comb begin
    w_req   = commit_valid_i & {2{en_i}};
    w_nreq  = 2'({1'b0, w_req[0]}) + 2'({1'b0, w_req[1]});
    w_free  = CW'(DEPTH) - r_occ;
    w_nacc  = 2'd0;
    if (w_free >= CW'(2)) begin
      w_nacc = w_nreq;
    end else if (w_free == CW'(1)) begin
      w_nacc = (w_nreq != 2'd0) ? 2'd1 : 2'd0;
    end
    w_ndrop    = w_nreq - w_nacc;
    w_pop      = rec_valid_o & rec_ready_i;
    w_wptr1    = r_wptr + AW'(1);
    w_drop_sum = 17'(r_drop_cnt) + 17'(w_ndrop);
  end

  // Per-port record assembly; exception records keep rd/fpr/wdata as presented
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rec[p] = {r_cycle, commit_pc_i[p], commit_instr_i[p], commit_rd_i[p],
                  commit_fpr_i[p], commit_wdata_i[p], commit_exc_i[p],
                  commit_cause_i[p]};
    end
    // When only one slot is granted, it goes to the oldest requesting port
    w_first_rec = w_req[0] ? w_rec[0] : w_rec[1];
  end

  // Control state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
      r_cycle    <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      r_wptr  <= r_wptr + AW'(w_nacc);
      r_rptr  <= r_rptr + AW'(w_pop);
      r_occ   <= r_occ + CW'(w_nacc) - CW'(w_pop);
      if (w_ndrop != 2'd0) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
    end
  end

  // Record storage, not reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (w_nacc != 2'd0) r_mem[r_wptr]  <= w_first_rec;
      if (w_nacc == 2'd2) r_mem[w_wptr1] <= w_rec[1];
    end
  end

  assign rec_valid_o = (r_occ != '0);
  assign {rec_cycle_o, rec_pc_o, rec_instr_o, rec_rd_o, rec_fpr_o,
          rec_wdata_o, rec_exc_o, rec_cause_o} = r_mem[r_rptr];
  assign drop_cnt_o  = r_drop_cnt;
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: directed table, multi-cycle corner sequences
// and randomized traffic against a queue-based reference model.
module tb_commit_trace_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned VLEN  = 39;
  localparam int unsigned XLEN  = 64;

  typedef struct packed {
    logic [31:0]     cyc;
    logic [VLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic            fpr;
    logic [XLEN-1:0] wdata;
    logic            exc;
    logic [5:0]      cause;
  } rec_t;

  typedef struct {
    bit              en;
    bit [1:0]        v;
    bit              rdy;
    logic [VLEN-1:0] pc0;
    logic [VLEN-1:0] pc1;
    bit              ex_valid;
    logic [VLEN-1:0] ex_pc;
    int unsigned     ex_drop;
    bit              ex_ov;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [1:0]           valid;
  logic [1:0][VLEN-1:0] pc;
  logic [1:0][31:0]     instr;
  logic [1:0][4:0]      rd;
  logic [1:0]           fpr;
  logic [1:0][XLEN-1:0] wdata;
  logic [1:0]           exc;
  logic [1:0][5:0]      cause;
  logic                 ready;

  logic                 rec_valid_o;
  logic [31:0]          rec_cycle_o;
  logic [VLEN-1:0]      rec_pc_o;
  logic [31:0]          rec_instr_o;
  logic [4:0]           rec_rd_o;
  logic                 rec_fpr_o;
  logic [XLEN-1:0]      rec_wdata_o;
  logic                 rec_exc_o;
  logic [5:0]           rec_cause_o;
  logic [15:0]          drop_cnt_o;
  logic                 overflow_o;

  rec_t dut_rec;
  assign dut_rec = '{cyc: rec_cycle_o, pc: rec_pc_o, instr: rec_instr_o,
                     rd: rec_rd_o, fpr: rec_fpr_o, wdata: rec_wdata_o,
                     exc: rec_exc_o, cause: rec_cause_o};

  commit_trace_buffer #(.DEPTH(DEPTH), .VLEN(VLEN), .XLEN(XLEN)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .commit_valid_i(valid), .commit_pc_i(pc), .commit_instr_i(instr),
    .commit_rd_i(rd), .commit_fpr_i(fpr), .commit_wdata_i(wdata),
    .commit_exc_i(exc), .commit_cause_i(cause),
    .rec_valid_o(rec_valid_o), .rec_ready_i(ready),
    .rec_cycle_o(rec_cycle_o), .rec_pc_o(rec_pc_o), .rec_instr_o(rec_instr_o),
    .rec_rd_o(rec_rd_o), .rec_fpr_o(rec_fpr_o), .rec_wdata_o(rec_wdata_o),
    .rec_exc_o(rec_exc_o), .rec_cause_o(rec_cause_o),
    .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  rec_t        mq[$];
  int unsigned mcyc;
  int unsigned mdrop;
  bit          mov;
  logic [VLEN-1:0] got_pc[$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic rand_fields();
    for (int p = 0; p < 2; p++) begin
      pc[p]    = VLEN'({$urandom(), $urandom()});
      instr[p] = $urandom();
      rd[p]    = 5'($urandom());
      fpr[p]   = 1'($urandom());
      wdata[p] = XLEN'({$urandom(), $urandom()});
      exc[p]   = ($urandom_range(0, 3) == 0);
      cause[p] = 6'($urandom());
    end
  endtask

  // One clock of the reference: stamp, push in port order while room, drop the rest
  task automatic model_apply();
    int room;
    int dropped;
    bit pop;
    rec_t r;
    if (rst) begin
      mq.delete();
      mcyc  = 0;
      mdrop = 0;
      mov   = 1'b0;
      return;
    end
    room    = DEPTH - mq.size();
    pop     = (mq.size() != 0) && ready;
    dropped = 0;
    for (int p = 0; p < 2; p++) begin
      if (en && valid[p]) begin
        if (room > 0) begin
          r = '{cyc: mcyc, pc: pc[p], instr: instr[p], rd: rd[p], fpr: fpr[p],
                wdata: wdata[p], exc: exc[p], cause: cause[p]};
          mq.push_back(r);
          room--;
        end else begin
          dropped++;
        end
      end
    end
    if (pop) void'(mq.pop_front());
    if (dropped > 0) begin
      mov   = 1'b1;
      mdrop = (mdrop + dropped > 65535) ? 65535 : mdrop + dropped;
    end
    mcyc = mcyc + 1;
  endtask

  task automatic check_model();
    chk("valid", rec_valid_o, mq.size() != 0);
    if (mq.size() != 0) chk("head", dut_rec, mq[0]);
    chk("drop_cnt", drop_cnt_o, mdrop);
    chk("overflow", overflow_o, mov);
  endtask

  // Called at posedge+1 with inputs set; returns at the next posedge+1
  task automatic step();
    if (rec_valid_o && ready) got_pc.push_back(rec_pc_o);
    model_apply();
    @(posedge clk);
    #1;
    check_model();
  endtask

  vec_t tbl[13];
  rec_t snap;

  initial begin
    rst = 1'b1; en = 1'b0; valid = '0; ready = 1'b0;
    rand_fields();
    model_apply();
    @(posedge clk);
    #1;
    chk("rst_valid", rec_valid_o, 1'b0);
    chk("rst_drop", drop_cnt_o, 16'h0);
    chk("rst_ovf", overflow_o, 1'b0);
    step();

    // en, v, rdy, pc0, pc1, ex_valid, ex_pc, ex_drop, ex_ov
    tbl[0]  = '{1, 2'b11, 1, 39'h80000000, 39'h80000004, 1, 39'h80000000, 0, 0};
    tbl[1]  = '{1, 2'b00, 1, 39'h0,        39'h0,        1, 39'h80000004, 0, 0};
    tbl[2]  = '{1, 2'b00, 1, 39'h0,        39'h0,        0, 39'h0,        0, 0};
    tbl[3]  = '{1, 2'b11, 0, 39'h100,      39'h104,      1, 39'h100,      0, 0};
    tbl[4]  = '{1, 2'b11, 0, 39'h108,      39'h10C,      1, 39'h100,      0, 0};
    tbl[5]  = '{1, 2'b11, 0, 39'h110,      39'h114,      1, 39'h100,      0, 0};
    tbl[6]  = '{1, 2'b01, 0, 39'h118,      39'h11C,      1, 39'h100,      0, 0};
    tbl[7]  = '{1, 2'b11, 1, 39'h200,      39'h204,      1, 39'h104,      1, 1};
    tbl[8]  = '{1, 2'b11, 0, 39'h300,      39'h304,      1, 39'h104,      2, 1};
    tbl[9]  = '{1, 2'b11, 0, 39'h400,      39'h404,      1, 39'h104,      4, 1};
    tbl[10] = '{1, 2'b00, 1, 39'h0,        39'h0,        1, 39'h108,      4, 1};
    tbl[11] = '{0, 2'b11, 0, 39'h500,      39'h504,      1, 39'h108,      4, 1};
    tbl[12] = '{0, 2'b11, 1, 39'h600,      39'h604,      1, 39'h10C,      4, 1};

    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      rand_fields();
      en = tbl[i].en; valid = tbl[i].v; ready = tbl[i].rdy;
      pc[0] = tbl[i].pc0; pc[1] = tbl[i].pc1;
      step();
      chk($sformatf("tbl%0d_valid", i), rec_valid_o, tbl[i].ex_valid);
      if (tbl[i].ex_valid) chk($sformatf("tbl%0d_pc", i), rec_pc_o, tbl[i].ex_pc);
      chk($sformatf("tbl%0d_drop", i), drop_cnt_o, tbl[i].ex_drop);
      chk($sformatf("tbl%0d_ovf", i), overflow_o, tbl[i].ex_ov);
      if (i < 2) chk($sformatf("tbl%0d_stamp", i), rec_cycle_o, 32'd0);
    end

    // Backpressure hold, then asynchronous reset
    rst = 1'b1; valid = '0; step();
    rst = 1'b0; en = 1'b1; ready = 1'b0;
    rand_fields(); valid = 2'b11; step();
    rand_fields(); valid = 2'b01; step();
    valid = 2'b00;
    snap = dut_rec;
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      step();
      chk("hold", dut_rec, snap);
    end
    rst = 1'b1;
    #1;
    chk("async_rst_valid", rec_valid_o, 1'b0);
    chk("async_rst_ovf", overflow_o, 1'b0);
    step();
    rst = 1'b0; rand_fields(); valid = 2'b01; pc[0] = 39'h777;
    step();
    chk("first_stamp", rec_cycle_o, 32'd0);
    chk("first_pc", rec_pc_o, 39'h777);

    // Continuous push/pop past pointer wrap
    rst = 1'b1; valid = '0; step();
    rst = 1'b0; ready = 1'b1; en = 1'b1;
    got_pc.delete();
    for (int i = 0; i < 20; i++) begin
      rand_fields(); valid = 2'b01; pc[0] = VLEN'(i);
      step();
    end
    valid = 2'b00;
    for (int i = 0; i < 3; i++) step();
    chk("wrap_count", got_pc.size(), 20);
    for (int i = 0; i < got_pc.size(); i++) chk($sformatf("wrap_pc%0d", i), got_pc[i], VLEN'(i));
    chk("wrap_drop", drop_cnt_o, 16'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rand_fields();
      en    = ($urandom_range(0, 9) != 0);
      valid = 2'($urandom());
      ready = ($urandom_range(0, 2) != 0);
      step();
    end

    // Drop counter saturation
    rst = 1'b1; step();
    rst = 1'b0; en = 1'b1; ready = 1'b0; valid = 2'b11;
    for (int i = 0; i < 4; i++) begin rand_fields(); step(); end
    for (int i = 0; i < 32767; i++) step();
    chk("sat_fffe", drop_cnt_o, 16'hFFFE);
    step();
    chk("sat_ffff", drop_cnt_o, 16'hFFFF);
    step();
    chk("sat_hold", drop_cnt_o, 16'hFFFF);
    chk("sat_ovf", overflow_o, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 8: number of FIFO record entries; power of two, at least 2.
REQ-002 Parameter VLEN, default 39: width of the PC field.
REQ-003 Parameter XLEN, default 64: width of the write-back data field.
REQ-004 clk_i  in  1  sole clock; all state is updated on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous and active-high.
REQ-006 en_i  in  1  capture enable; when 0, no records are pushed and no drops are counted.
REQ-007 commit_valid_i  in  2  per-port retire strobe; port 0 is architecturally older than port 1.
REQ-008 commit_pc_i  in  2xVLEN  per-port PC.
REQ-009 commit_instr_i  in  2x32  per-port instruction word.
REQ-010 commit_rd_i  in  2x5  per-port destination register index.
REQ-011 commit_fpr_i  in  2  per-port flag: destination is an FP register.
REQ-012 commit_wdata_i  in  2xXLEN  per-port write-back value.
REQ-013 commit_exc_i  in  2  per-port flag: the record is an exception rather than a retirement.
REQ-014 commit_cause_i  in  2x6  per-port exception cause.
REQ-015 rec_valid_o  out  1  output record available.
REQ-016 rec_ready_i  in  1  consumer accepts the record.
REQ-017 rec_cycle_o  out  32  cycle stamp of the record.
REQ-018 rec_pc_o, rec_instr_o, rec_rd_o, rec_fpr_o, rec_wdata_o, rec_exc_o, rec_cause_o  out  field widths as in REQ-008 to REQ-014  record payload.
REQ-019 drop_cnt_o  out  16  saturating count of records lost to overflow.
REQ-020 overflow_o  out  1  sticky flag: at least one record has been dropped since reset.

Function
REQ-021 A free-running 32-bit cycle counter shall increment every cycle, wrap from 0xFFFFFFFF to 0, and stamp every record pushed in that cycle with its current value.
REQ-022 Each cycle the block shall push up to two records in port order: port 0 first, then port 1.
- A record is pushed only if its commit_valid_i bit is 1 and en_i is 1.
REQ-023 Capacity shall be computed from the occupancy at the start of the cycle; a pop in the same cycle shall not create room for that cycle's pushes.
REQ-024 Records that do not fit shall be dropped:
- port 1 is dropped first; port 0 is dropped only if occupancy equals DEPTH.
- drop_cnt_o increments by the number dropped (0, 1 or 2) and saturates at 0xFFFF.
- overflow_o sets to 1.
REQ-025 The FIFO shall be a circular buffer with read and write pointers that wrap modulo DEPTH, plus an occupancy count of width log2(DEPTH)+1.
REQ-026 rec_valid_o shall equal (occupancy != 0); the output fields shall present the head entry combinationally from storage.
REQ-027 A pop shall occur when rec_valid_o and rec_ready_i are both 1.
- Occupancy next = occupancy + pushes - pop, in the same cycle.
REQ-028 Latency: a record pushed in cycle N shall be visible on the outputs in cycle N+1 at the earliest.
REQ-029 While rec_valid_o is 1 and rec_ready_i is 0, all rec_* outputs shall remain stable.
REQ-030 Output order shall equal push order; no reordering between ports or between cycles.
REQ-031 Deasserting en_i shall not affect the contents already queued; popping shall continue.
REQ-032 For records with commit_exc_i=1, the wdata, rd and fpr fields shall be stored as presented, without masking.

Reset
REQ-033 While rst_i is 1:
- pointers, occupancy and the cycle counter are 0;
- drop_cnt_o=0, overflow_o=0, rec_valid_o=0.
REQ-034 Reset asserted mid-operation shall discard all queued records immediately.
- FIFO storage contents need not be reset.
REQ-035 After rst_i deasserts, the first clock edge shall count cycle 0 to 1.
- A record pushed on that edge shall carry stamp 0.

Verification
REQ-036 Dual retire: DEPTH=8, empty, en_i=1, both ports valid (pc 0x80000000, 0x80000004), rec_ready_i=1 -> next cycle the port-0 record is presented, then the port-1 record one cycle later, with equal stamps.
REQ-037 Overflow: occupancy 7, rec_ready_i=1, both ports valid -> port 0 stored; drop_cnt_o=1; overflow_o=1; occupancy stays 7.
REQ-038 Full FIFO with double push: occupancy 8, rec_ready_i=0, both valid -> drop_cnt_o +2; overflow_o=1; outputs unchanged.
REQ-039 Saturation: force 0xFFFE drops, then a double drop -> drop_cnt_o=0xFFFF and stays there.
REQ-040 Backpressure and reset: queue 3 records, hold rec_ready_i=0 for 5 cycles -> outputs stable. Then assert rst_i -> rec_valid_o=0 asynchronously; after release, the stamp of the first push is 0.
REQ-041 Wrap: push and pop 20 records continuously with DEPTH=8 -> all 20 emerge in order, drop_cnt_o=0.
